// File: rtl/npu_inst_fetch.sv
// npu_inst_fetch: reader side of the 128 x 512 instruction SRAM.
//
// Purpose
//   Walks the program counter from a start address and issues SRAM reads.
//   Each read returns one cycle later and is captured into a 2-entry output
//   buffer that hides the SRAM latency. Words go to the decoder over a
//   valid/ready handshake. Fetching stops when a word carrying the HALT
//   opcode enters the buffer; done pulses when that word is accepted.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   start, start_addr  launch pulse (IDLE/DONE only) and first address
//   sram_addr/we/d     SRAM address, write enable, write data
//   sram_q             SRAM read data, valid the cycle after sram_addr
//   inst_valid/ready   decoder handshake
//   inst_data/pc/last  head word, its fetch address, HALT marker
//   busy, done         FETCH|DRAIN status, 1-cycle pulse on HALT acceptance
//   wrap_err           sticky: PC wrapped 511->0 before HALT, cleared by start
//
// Configuration
//   INST_LOADER_EN  adds load_en/load_addr/load_data so the host can write
//                   the program while the fetcher is IDLE or DONE. When the
//                   macro is undefined sram_we and sram_d are tied to 0.
module npu_inst_fetch #(
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned ADDR_W  = 9,
  parameter logic [3:0]  HALT_OP = 4'h8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_we,
  output logic [DATA_W-1:0] sram_d,
  input  logic [DATA_W-1:0] sram_q,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_last,
  output logic              busy,
  output logic              done,
  output logic              wrap_err
`ifdef INST_LOADER_EN
  ,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              inflight_q, inflight_d;
  logic              wrap_err_q, wrap_err_d;
  logic [1:0]        count_q, count_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;

  logic [DATA_W-1:0] buf_data_q [2];
  logic [ADDR_W-1:0] buf_pc_q   [2];
  logic              buf_last_q [2];

  logic              idle_like, load_req, start_go, pop, wr_en, halt_in, issue;
  logic              head_last;
  logic [ADDR_W-1:0] issue_addr;
  logic [1:0]        occ;

  assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);

`ifdef INST_LOADER_EN
  assign load_req = idle_like && load_en;
  assign sram_we  = load_req;
  assign sram_d   = load_req ? load_data : '0;
`else
  assign load_req = 1'b0;
  assign sram_we  = 1'b0;
  assign sram_d   = '0;
`endif

  // A load in the same cycle as start takes priority.
  assign start_go   = idle_like && start && !load_req;
  assign inst_valid = (count_q != 2'd0);
  assign head_last  = buf_last_q[rd_ptr_q];
  assign pop        = inst_valid && inst_ready;

  // Returning words are only kept while still fetching; a read issued in
  // the cycle the HALT word lands comes back in DRAIN and is dropped.
  assign wr_en   = inflight_q && (state_q == S_FETCH);
  assign halt_in = wr_en && (sram_q[DATA_W-1 -: 4] == HALT_OP);

  // Occupancy counts the word already in flight. A pop in the same cycle
  // frees a slot, which is what allows one word per cycle when ready is high.
  assign occ   = count_q + {1'b0, inflight_q};
  assign issue = start_go ||
                 ((state_q == S_FETCH) && (occ < (pop ? 2'd3 : 2'd2)));

  // The first read goes out in the start cycle itself, so the first word is
  // visible two cycles after start.
  assign issue_addr = start_go ? start_addr : pc_q;

  always_comb begin
    sram_addr = addr_q;
    if (issue) sram_addr = issue_addr;
`ifdef INST_LOADER_EN
    if (load_req) sram_addr = load_addr;
`endif
  end

  // addr_q doubles as the fetch address of the word returning next cycle.
  assign addr_d = sram_addr;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inflight_d = issue;
    wrap_err_d = wrap_err_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q ^ pop;
    wr_ptr_d   = wr_ptr_q ^ wr_en;

    case ({wr_en, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    if (issue) pc_d = issue_addr + PC_ONE;

    if (start_go) wrap_err_d = 1'b0;
    if (issue && (issue_addr == '1)) wrap_err_d = 1'b1;

    case (state_q)
      S_IDLE, S_DONE: if (start_go) state_d = S_FETCH;
      S_FETCH:        if (halt_in) state_d = S_DRAIN;
      S_DRAIN:        if (pop && head_last) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      wrap_err_q <= 1'b0;
      count_q    <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      inflight_q <= inflight_d;
      wrap_err_q <= wrap_err_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Buffer payload carries no reset; occupancy is tracked by count_q and
  // the outputs are masked while the buffer is empty.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      buf_data_q[wr_ptr_q] <= sram_q;
      buf_pc_q[wr_ptr_q]   <= addr_q;
      buf_last_q[wr_ptr_q] <= halt_in;
    end
  end

  assign inst_data = inst_valid ? buf_data_q[rd_ptr_q] : '0;
  assign inst_pc   = inst_valid ? buf_pc_q[rd_ptr_q] : '0;
  assign inst_last = inst_valid && head_last;
  assign done      = (state_q == S_DRAIN) && pop && head_last;
  assign busy      = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign wrap_err  = wrap_err_q;

endmodule
